// File: rtl/wb_mem_tester.sv
// wb_mem_tester: Wishbone BIST initiator. Writes an LFSR pattern over a word
// range, reads it back, and reports pass/fail, error count, first failing
// address and ack timeouts.
// Optional build macro MEMTEST_ADDR_XOR_EN: data = pattern XOR word address,
// so aliased address lines show up as mismatches.
module wb_mem_tester #(
  parameter int unsigned LEN_WIDTH = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start_i,
  input  logic [31:0]          base_adr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic [31:0]          seed_i,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [3:0]           wbm_sel_o,
  output logic [31:0]          wbm_adr_o,
  output logic [31:0]          wbm_dat_o,
  input  logic [31:0]          wbm_dat_i,
  input  logic                 wbm_ack_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 timeout_o,
  output logic [15:0]          err_cnt_o,
  output logic [31:0]          first_err_adr_o
);

  typedef enum logic [2:0] {
    StIdle, StWrReq, StWrWait, StRdReq, StRdWait, StFinish
  } state_e;

  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [31:0]          base_q, base_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]          seed_q, seed_d;
  logic [31:0]          lfsr_q, lfsr_d;
  logic [7:0]           tmo_q, tmo_d;
  logic                 cyc_q, cyc_d;
  logic                 we_q, we_d;
  logic [31:0]          adr_q, adr_d;
  logic [31:0]          dat_q, dat_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 timeout_q, timeout_d;
  logic [15:0]          err_q, err_d;
  logic [31:0]          first_q, first_d;

  logic [31:0]          word_adr;
  logic [31:0]          wr_pat;
  logic [31:0]          rd_exp;
  logic                 last_word;
  logic [31:0]          seed_in;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], 1'b0} ^ (l[31] ? 32'h0040_0007 : 32'h0);
  endfunction

  assign word_adr  = base_q + (32'(idx_q) << 2);
  assign last_word = (idx_q == (len_q - LEN_WIDTH'(1)));
  assign seed_in   = (seed_i == 32'h0) ? 32'h1 : seed_i;

`ifdef MEMTEST_ADDR_XOR_EN
  assign wr_pat = lfsr_q ^ word_adr;
  assign rd_exp = lfsr_q ^ adr_q;
`else
  assign wr_pat = lfsr_q;
  assign rd_exp = lfsr_q;
`endif

  // Next-state and registered-output logic for the test sequencer.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    idx_d     = idx_q;
    seed_d    = seed_q;
    lfsr_d    = lfsr_q;
    tmo_d     = tmo_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    err_d     = err_q;
    first_d   = first_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          base_d    = {base_adr_i[31:2], 2'b00};
          len_d     = len_i;
          seed_d    = seed_in;
          lfsr_d    = seed_in;
          idx_d     = '0;
          busy_d    = 1'b1;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          err_d     = 16'h0;
          first_d   = 32'h0;
          state_d   = (len_i == '0) ? StFinish : StWrReq;
        end
      end
      StWrReq: begin
        cyc_d   = 1'b1;
        we_d    = 1'b1;
        adr_d   = word_adr;
        dat_d   = wr_pat;
        tmo_d   = 8'h0;
        state_d = StWrWait;
      end
      StWrWait: begin
        if (wbm_ack_i) begin
          cyc_d = 1'b0;
          we_d  = 1'b0;
          if (last_word) begin
            idx_d   = '0;
            lfsr_d  = seed_q;
            state_d = StRdReq;
          end else begin
            idx_d   = idx_q + LEN_WIDTH'(1);
            lfsr_d  = lfsr_step(lfsr_q);
            state_d = StWrReq;
          end
        end else if (tmo_q == TmoLast) begin
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          timeout_d = 1'b1;
          state_d   = StFinish;
        end else begin
          tmo_d = tmo_q + 8'h1;
        end
      end
      StRdReq: begin
        cyc_d   = 1'b1;
        we_d    = 1'b0;
        adr_d   = word_adr;
        tmo_d   = 8'h0;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (wbm_ack_i) begin
          cyc_d = 1'b0;
          if (wbm_dat_i != rd_exp) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'h1;
            // Nonzero count means an earlier mismatch already got captured.
            if (err_q == 16'h0) first_d = adr_q;
          end
          if (last_word) begin
            state_d = StFinish;
          end else begin
            idx_d   = idx_q + LEN_WIDTH'(1);
            lfsr_d  = lfsr_step(lfsr_q);
            state_d = StRdReq;
          end
        end else if (tmo_q == TmoLast) begin
          cyc_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = StFinish;
        end else begin
          tmo_d = tmo_q + 8'h1;
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_q == 16'h0) && !timeout_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; reset drops the bus immediately and clears all status.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      base_q    <= 32'h0;
      len_q     <= '0;
      idx_q     <= '0;
      seed_q    <= 32'h1;
      lfsr_q    <= 32'h1;
      tmo_q     <= 8'h0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= 32'h0;
      dat_q     <= 32'h0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 16'h0;
      first_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      seed_q    <= seed_d;
      lfsr_q    <= lfsr_d;
      tmo_q     <= tmo_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      first_q   <= first_d;
    end
  end

  assign wbm_cyc_o       = cyc_q;
  assign wbm_stb_o       = cyc_q;
  assign wbm_we_o        = we_q;
  assign wbm_sel_o       = cyc_q ? 4'hF : 4'h0;
  assign wbm_adr_o       = adr_q;
  assign wbm_dat_o       = dat_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign timeout_o       = timeout_q;
  assign err_cnt_o       = err_q;
  assign first_err_adr_o = first_q;

endmodule

// File: tb/tb_wb_mem_tester.sv
// Testbench for wb_mem_tester: table-driven runs against a configurable
// memory responder, plus hand-written reset / len=0 / busy-start sequences.
module tb_wb_mem_tester;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base = 32'h0;
  logic [15:0] len = 16'h0;
  logic [31:0] seed = 32'h0;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, rdat;
  logic        ack;
  logic        busy, done, pass, tmo;
  logic [15:0] err_cnt;
  logic [31:0] first_adr;

  always #5 clk = ~clk;

  wb_mem_tester #(.LEN_WIDTH(16), .TIMEOUT(255)) dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .start_i         (start),
    .base_adr_i      (base),
    .len_i           (len),
    .seed_i          (seed),
    .wbm_cyc_o       (cyc),
    .wbm_stb_o       (stb),
    .wbm_we_o        (we),
    .wbm_sel_o       (sel),
    .wbm_adr_o       (adr),
    .wbm_dat_o       (wdat),
    .wbm_dat_i       (rdat),
    .wbm_ack_i       (ack),
    .busy_o          (busy),
    .done_o          (done),
    .pass_o          (pass),
    .timeout_o       (tmo),
    .err_cnt_o       (err_cnt),
    .first_err_adr_o (first_adr)
  );

  // Responder configuration.
  int          ack_delay = 0;
  bit          ack_en = 1'b1;
  bit          corr_en = 1'b0;
  logic [31:0] corr_adr = 32'h0;

  logic [31:0] mem [256];
  int          wcnt = 0;

  assign ack  = cyc && stb && ack_en && (wcnt == ack_delay);
  assign rdat = mem[adr[9:2]] ^ ((corr_en && adr == corr_adr) ? 32'h1 : 32'h0);

  // Monitor counters, write log and protocol checking.
  int          cyc_cycles = 0, done_cnt = 0, viol = 0, rd_n = 0;
  logic [31:0] wr_adr_q[$];
  logic [31:0] wr_dat_q[$];
  logic        prev_hold = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_adr = 32'h0, prev_dat = 32'h0;

  always @(posedge clk) begin
    wcnt <= (!cyc || ack) ? 0 : wcnt + 1;
    if (cyc) cyc_cycles <= cyc_cycles + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (cyc && ack && we) begin
      mem[adr[9:2]] <= wdat;
      wr_adr_q.push_back(adr);
      wr_dat_q.push_back(wdat);
    end
    if (cyc && ack && !we) rd_n <= rd_n + 1;
    if ((prev_hold && cyc && (adr != prev_adr || wdat != prev_dat || we != prev_we)) ||
        (prev_ack && cyc) || (cyc && (!stb || sel != 4'hF)) || (!cyc && stb))
      viol <= viol + 1;
    prev_hold <= cyc && !ack;
    prev_ack  <= cyc && ack;
    prev_adr  <= adr;
    prev_dat  <= wdat;
    prev_we   <= we;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_step(input logic [31:0] l);
    return {l[30:0], 1'b0} ^ (l[31] ? 32'h0040_0007 : 32'h0);
  endfunction

  typedef struct {
    logic [31:0] seed;
    logic [31:0] base;
    logic [15:0] len;
    int          delay;
    bit          ack_en;
    bit          corr_en;
    logic [31:0] corr_adr;
    bit          exp_pass;
    bit          exp_tmo;
    logic [15:0] exp_err;
    logic [31:0] exp_first;
  } vec_t;

  vec_t vecs[7];

  task automatic run_test(input vec_t v, input string tag);
    int          wr0, rd0, cyc0, done0, viol0, exp_wr, exp_rd;
    bit          found;
    logic [31:0] l, a, e;
    ack_delay = v.delay;
    ack_en    = v.ack_en;
    corr_en   = v.corr_en;
    corr_adr  = v.corr_adr;
    @(negedge clk);
    wr0 = wr_adr_q.size(); rd0 = rd_n; cyc0 = cyc_cycles; done0 = done_cnt; viol0 = viol;
    base = v.base; len = v.len; seed = v.seed; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (done) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, " done seen"}, 32'(found), 32'd1);
    check({tag, " busy at done"}, 32'(busy), 32'd0);
    check({tag, " pass"}, 32'(pass), 32'(v.exp_pass));
    check({tag, " timeout"}, 32'(tmo), 32'(v.exp_tmo));
    check({tag, " err_cnt"}, 32'(err_cnt), 32'(v.exp_err));
    check({tag, " first_err"}, first_adr, v.exp_first);
    repeat (3) @(negedge clk);
    check({tag, " done once"}, 32'(done_cnt - done0), 32'd1);
    check({tag, " protocol"}, 32'(viol - viol0), 32'd0);
    exp_wr = v.ack_en ? int'(v.len) : 0;
    exp_rd = v.ack_en ? int'(v.len) : 0;
    check({tag, " writes"}, 32'(wr_adr_q.size() - wr0), 32'(exp_wr));
    check({tag, " reads"}, 32'(rd_n - rd0), 32'(exp_rd));
    if (!v.ack_en) check({tag, " cyc cycles"}, 32'(cyc_cycles - cyc0), 32'd255);
    l = (v.seed == 32'h0) ? 32'h1 : v.seed;
    for (int i = 0; i < exp_wr && (wr0 + i) < wr_adr_q.size(); i++) begin
      a = {v.base[31:2], 2'b00} + 32'(i) * 32'd4;
      e = l;
`ifdef MEMTEST_ADDR_XOR_EN
      e = e ^ a;
`endif
      check($sformatf("%s wr%0d adr", tag, i), wr_adr_q[wr0 + i], a);
      check($sformatf("%s wr%0d dat", tag, i), wr_dat_q[wr0 + i], e);
      l = model_step(l);
    end
  endtask

  initial begin
    int          cyc0;
    bit          found;
    //        seed          base          len  dly   ack  corr  corr_adr      pass tmo err first
    vecs[0] = '{32'h1, 32'h3000_0000, 16'd3, 0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 16'd0, 32'h0};
    vecs[1] = '{32'hDEAD_BEEF, 32'h2000, 16'd4, 5, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 16'd0, 32'h0};
    vecs[2] = '{32'h5, 32'h100, 16'd4, 0, 1'b1, 1'b1, 32'h108, 1'b0, 1'b0, 16'd1, 32'h108};
    vecs[3] = '{32'h7, 32'h40, 16'd2, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 16'd0, 32'h0};
    vecs[4] = '{32'h0, 32'h203, 16'd2, 1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 16'd0, 32'h0};
    vecs[5] = '{32'h8000_0001, 32'hFFFF_FFF8, 16'd4, 0, 1'b1, 1'b0, 32'h0,
                1'b1, 1'b0, 16'd0, 32'h0};
    // Ack lands on the same cycle the timeout would fire.
    vecs[6] = '{32'h3, 32'h80, 16'd1, 254, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 16'd0, 32'h0};

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst cyc", 32'(cyc), 32'd0);
    check("rst stb", 32'(stb), 32'd0);
    check("rst we", 32'(we), 32'd0);
    check("rst sel", 32'(sel), 32'd0);
    check("rst adr", adr, 32'h0);
    check("rst dat", wdat, 32'h0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst pass", 32'(pass), 32'd0);
    check("rst timeout", 32'(tmo), 32'd0);
    check("rst err_cnt", 32'(err_cnt), 32'd0);
    check("rst first_err", first_adr, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_test(vecs[i], $sformatf("v%0d", i));
`ifndef MEMTEST_ADDR_XOR_EN
      if (i == 0 && wr_dat_q.size() >= 3) begin
        check("v0 word0 const", wr_dat_q[0], 32'h1);
        check("v0 word1 const", wr_dat_q[1], 32'h2);
        check("v0 word2 const", wr_dat_q[2], 32'h4);
        check("v0 adr2 const", wr_adr_q[2], 32'h3000_0008);
      end
`endif
    end

    // len=0: done two cycles after start, no bus traffic; start while busy ignored.
    ack_en = 1'b1; ack_delay = 0; corr_en = 1'b0;
    @(negedge clk);
    cyc0 = cyc_cycles;
    len = 16'd0; base = 32'h500; seed = 32'h9; start = 1'b1;
    @(negedge clk);
    check("len0 done early", 32'(done), 32'd0);
    check("len0 busy", 32'(busy), 32'd1);
    len = 16'd5;
    @(negedge clk);
    start = 1'b0;
    check("len0 done", 32'(done), 32'd1);
    check("len0 pass", 32'(pass), 32'd1);
    check("len0 busy end", 32'(busy), 32'd0);
    @(negedge clk);
    check("len0 start ignored", 32'(busy), 32'd0);
    check("len0 done pulse", 32'(done), 32'd0);
    @(negedge clk);
    check("len0 no bus", 32'(cyc_cycles - cyc0), 32'd0);

    // Asynchronous reset while waiting on a read ack.
    ack_delay = 20;
    base = 32'h600; len = 16'd2; seed = 32'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (cyc && !we) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rdwait reached", 32'(found), 32'd1);
    repeat (3) @(negedge clk);
    check("rdwait cyc before rst", 32'(cyc), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst cyc", 32'(cyc), 32'd0);
    check("midrst stb", 32'(stb), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst pass", 32'(pass), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_test(vecs[0], "after rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
